// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams bytes into 32-bit instruction words (little-endian),
// writes one word per WRITE cycle and keeps the core stalled until done.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (trailing XOR checksum byte).
// Handshake: a byte moves only on a cycle where byte_valid && byte_ready;
// byte_ready is decoded from state alone, so it never depends on byte_valid.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

`ifdef IMEM_BOOT_CHECKSUM_EN
  // After the data words (or immediately for an empty load) the checksum byte follows.
  localparam state_t S_AFTER = S_CHECK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        lane_q;
  logic [23:0]       asm_q;
  logic [ADDR_W:0]   n_sat;
  logic              last_word;
  logic              start_ok;

  assign n_sat     = (num_words > DEPTH_N) ? DEPTH_N : num_words;
  assign last_word = ({1'b0, word_idx_q} == (n_q - ONE_N));
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (n_sat == '0) ? S_AFTER : S_RECV;
      end
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (lane_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        state_d = last_word ? S_AFTER : S_RECV;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = (n_sat == '0) ? S_AFTER : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The core runs only once a load has finished cleanly
  assign cpu_stall = !(done && !error);

  // Word assembly, counters and the write-port registers (which hold between writes)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      word_idx_q <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else if (start_ok) begin
      n_q        <= n_sat;
      word_idx_q <= '0;
      lane_q     <= '0;
    end else if ((state_q == S_RECV) && byte_valid) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0: asm_q[7:0]   <= byte_data;
        2'd1: asm_q[15:8]  <= byte_data;
        2'd2: asm_q[23:16] <= byte_data;
        default: begin
          imem_wdata <= {byte_data, asm_q};
          imem_waddr <= {{(30-ADDR_W){1'b0}}, word_idx_q, 2'b00};
        end
      endcase
    end else if (state_q == S_WRITE) begin
      word_idx_q <= word_idx_q + 1'b1;
      lane_q     <= '0;
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       error_q;

  // Running XOR of data bytes; the trailing byte must match it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (start_ok) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if ((state_q == S_RECV) && byte_valid) begin
      csum_q <= csum_q ^ byte_data;
    end else if ((state_q == S_CHECK) && byte_valid && (byte_data != csum_q)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random byte streams, little-endian word model,
// write scoreboard checked every cycle, plus literal pins for the model.
`timescale 1ns/1ps
module tb_imem_boot_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [31:0]       imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_stall;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_stall(cpu_stall), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          checks = 0;
  int          passes = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream_q[$];
  time         we_time_q[$];
  time         done_time;
  int          wr_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: word w of the stream, little-endian
  function automatic logic [31:0] le_word(input int w);
    return {stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1], stream_q[4*w]};
  endfunction

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      prev_addr = '0;
      prev_data = '0;
    end else begin
      check("stall_rule", cpu_stall, !(done && !error));
      if (imem_we) begin
        wr_count++;
        we_time_q.push_back($time);
        last_waddr = imem_waddr;
        check("ready_low_on_write", byte_ready, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_waddr, imem_wdata);
        end else begin
          check("write_addr_data", {imem_waddr, imem_wdata}, exp_q.pop_front());
        end
        prev_addr = imem_waddr;
        prev_data = imem_wdata;
      end else begin
        check("hold_addr_data", {imem_waddr, imem_wdata}, {prev_addr, prev_data});
      end
    end
  end

  // Driver tasks (all entered and left at posedge+1)
  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) begin
      check("busy_after_start", busy, 1'b1);
      check("done_clear_after_start", done, 1'b0);
      check("stall_after_start", cpu_stall, 1'b1);
    end
  endtask

  task automatic send_stream(input int gap, input int start_at);
    int idx;
    int guard;
    bit pulsed;
    bit hold;
    bit accepted;
    idx = 0; guard = 0; pulsed = 0; hold = 0;
    while (idx < stream_q.size() && guard < 20000) begin
      if (hold || $urandom_range(99) >= gap) begin
        byte_valid = 1'b1;
        byte_data  = stream_q[idx];
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      if (idx == start_at && !pulsed) begin
        start = 1'b1; num_words = 9'd5; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hold     = byte_valid && !byte_ready;
      accepted = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (guard >= 20000) begin
      checks++;
      $display("FAIL stream_timeout: got %0d bytes accepted, expected %0d", idx, stream_q.size());
    end
  endtask

  task automatic wait_done(input int exp_writes, input int wr_base, input logic exp_err);
    int guard;
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      if (done) break;
      guard++;
    end
    done_time = $time;
    check("done", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("ready_at_done", byte_ready, 1'b0);
    check("error_at_done", error, exp_err);
    check("stall_at_done", cpu_stall, exp_err);
    check("write_count", wr_count - wr_base, exp_writes);
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Push expected writes for a load of n_req words; append checksum byte if enabled
  task automatic prepare(input int n_req, input bit bad, output logic exp_err);
    int n_eff;
    logic [7:0] x;
    n_eff = (n_req > DEPTH) ? DEPTH : n_req;
    x = 8'h00;
    for (int w = 0; w < n_eff; w++) exp_q.push_back({32'(w*4), le_word(w)});
    for (int i = 0; i < 4*n_eff; i++) x = x ^ stream_q[i];
`ifdef IMEM_BOOT_CHECKSUM_EN
    stream_q.push_back(bad ? ~x : x);
    exp_err = bad;
`else
    exp_err = 1'b0;
    if (bad) x = 8'h00;
`endif
  endtask

  task automatic fill_random(input int nbytes);
    stream_q.delete();
    for (int i = 0; i < nbytes; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic load_test2_stream();
    stream_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  // Main sequence
  initial begin
    int   base;
    logic e;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    #23;
    check("rst_stall", cpu_stall, 1'b1);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_waddr", imem_waddr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model against hand-computed words
    load_test2_stream();
    check("model_pin_w0", le_word(0), 32'h00000013);
    check("model_pin_w1", le_word(1), 32'h00100093);

    // Two words back-to-back, literal expectations
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h00100093});
`ifdef IMEM_BOOT_CHECKSUM_EN
    stream_q.push_back(8'h90);  // XOR of the eight data bytes
`endif
    we_time_q.delete();
    base = wr_count;
    do_start(2);
    send_stream(0, -1);
    wait_done(2, base, 1'b0);
    if (we_time_q.size() == 2) begin
      check("word_spacing_cycles", (we_time_q[1] - we_time_q[0]) / 10, 5);
`ifndef IMEM_BOOT_CHECKSUM_EN
      check("done_after_last_write", (done_time - we_time_q[1]) / 10, 1);
`endif
    end else begin
      checks++;
      $display("FAIL write_pulses: got %0d, expected 2", we_time_q.size());
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Wrong checksum keeps the core stalled
    load_test2_stream();
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h00100093});
    stream_q.push_back(8'h00);
    base = wr_count;
    do_start(2);
    send_stream(0, -1);
    wait_done(2, base, 1'b1);
`endif

    // Same stream with random valid gaps
    for (int r = 0; r < 3; r++) begin
      load_test2_stream();
      prepare(2, 1'b0, e);
      base = wr_count;
      do_start(2);
      send_stream(50, -1);
      wait_done(2, base, e);
    end

    // Empty load
    stream_q.delete();
    prepare(0, 1'b0, e);
    base = wr_count;
    do_start(0);
    send_stream(0, -1);
    wait_done(0, base, e);

    // Oversized request saturates at DEPTH words
    fill_random(4*DEPTH);
    prepare(300, 1'b0, e);
    base = wr_count;
    do_start(300);
    send_stream(0, -1);
    wait_done(DEPTH, base, e);
    check("top_word_addr", last_waddr, 32'h3FC);

    // Reset after two bytes of word 0, asserted mid-cycle
    stream_q = '{8'h11, 8'h22};
    do_start(1);
    send_stream(0, -1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", cpu_stall, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_we", imem_we, 1'b0);
    check("midrst_ready", byte_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full reload of one word, with a start pulse mid-load
    stream_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    check("model_pin_aabbccdd", le_word(0), 32'hAABBCCDD);
    prepare(1, 1'b0, e);
    base = wr_count;
    do_start(1);
    send_stream(0, 2);
    wait_done(1, base, e);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(4*n);
      prepare(n, (r == 3), e);
      base = wr_count;
      do_start(n);
      send_stream((r % 2) ? 50 : 0, -1);
      wait_done(n, base, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
